// File: rtl/sgd_grad_gen.sv
// ---------------------------------------------------------------------------
// sgd_grad_gen
//
// Forward/error half of the Axiline SGD training datapath. One sample vector
// is streamed in as (x, w) element pairs. The block accumulates the dot
// product w.x, subtracts the label y, scales the error by the learning rate
// mu, and presents the result as the scalar gradient term that every
// sgd_stage weight-update lane consumes as data_in.
//
// All arithmetic is unsigned and wraps modulo 2^bitwidth. This matches the
// truncation done in sgd_stage.
//
// Parameters
//   bitwidth       width of weights, accumulator, label and gradient
//   inputBitwidth  width of feature x and learning rate mu (<= bitwidth)
//   num_elem       elements per sample vector (>= 1)
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous, active-high reset
//   in_valid   in   element beat valid
//   in_ready   out  block accepts an element beat (high only while accumulating)
//   x          in   feature element
//   w          in   weight element
//   y          in   label, taken only from the final beat of a vector
//   mu         in   learning rate, taken only from the final beat of a vector
//   out_valid  out  grad is valid
//   out_ready  in   downstream accepts grad
//   grad       out  registered (acc - y) * mu
//   elem_idx   out  index of the next expected element
// ---------------------------------------------------------------------------
module sgd_grad_gen #(
    parameter int bitwidth      = 16,
    parameter int inputBitwidth = 8,
    parameter int num_elem      = 8,
    localparam int IdxW         = (num_elem > 1) ? $clog2(num_elem) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [inputBitwidth-1:0] x,
    input  logic [bitwidth-1:0]      w,
    input  logic [bitwidth-1:0]      y,
    input  logic [inputBitwidth-1:0] mu,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [bitwidth-1:0]      grad,
    output logic [IdxW-1:0]          elem_idx
);

    // Only one vector is in flight at a time: it is accumulated in ACC,
    // turned into a gradient in CALC, and held in OUT until downstream
    // takes it.
    typedef enum logic [1:0] {
        ACC  = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(num_elem - 1);

    state_t                stateQ, stateD;
    logic [bitwidth-1:0]   accQ,   accD;
    logic [bitwidth-1:0]   yQ,     yD;
    logic [inputBitwidth-1:0] muQ, muD;
    logic [bitwidth-1:0]   gradQ,  gradD;
    logic [IdxW-1:0]       idxQ,   idxD;

    logic [bitwidth-1:0]   xExt;
    logic [bitwidth-1:0]   muExt;
    logic [bitwidth-1:0]   beatProd;
    logic [bitwidth-1:0]   errVal;
    logic [bitwidth-1:0]   gradProd;
    logic                  lastBeat;

    // Narrow operands are zero-extended so that both multiplies are
    // evaluated at bitwidth. Only the low bitwidth bits of each product
    // are kept, which is the wrap-around the weight-update lanes expect.
    always_comb begin
        xExt     = bitwidth'(x);
        muExt    = bitwidth'(muQ);
        beatProd = w * xExt;
        errVal   = accQ - yQ;
        gradProd = errVal * muExt;
        lastBeat = (idxQ == LastIdx);
    end

    // Next-state and datapath update. Every register holds unless a case
    // below says otherwise. A beat is accepted only in ACC, because
    // in_ready is exactly "state is ACC". When num_elem is 1, LastIdx is 0,
    // so every beat is both the first and the final beat.
    always_comb begin
        stateD = stateQ;
        accD   = accQ;
        yD     = yQ;
        muD    = muQ;
        gradD  = gradQ;
        idxD   = idxQ;

        case (stateQ)
            ACC: begin
                if (in_valid) begin
                    accD = accQ + beatProd;
                    if (lastBeat) begin
                        yD     = y;
                        muD    = mu;
                        idxD   = '0;
                        stateD = CALC;
                    end else begin
                        idxD = idxQ + IdxW'(1);
                    end
                end
            end

            CALC: begin
                gradD  = gradProd;
                stateD = OUT;
            end

            OUT: begin
                // Clearing acc on the handshake lets the next vector start
                // from zero on the very next accepted beat.
                if (out_ready) begin
                    accD   = '0;
                    stateD = ACC;
                end
            end

            default: begin
                stateD = ACC;
            end
        endcase
    end

    // State registers. Reset drops any partial vector or pending gradient
    // and returns the block to accepting beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= ACC;
            accQ   <= '0;
            yQ     <= '0;
            muQ    <= '0;
            gradQ  <= '0;
            idxQ   <= '0;
        end else begin
            stateQ <= stateD;
            accQ   <= accD;
            yQ     <= yD;
            muQ    <= muD;
            gradQ  <= gradD;
            idxQ   <= idxD;
        end
    end

    // The handshake outputs are decoded from the registered state only.
    // This keeps in_valid and out_ready off any combinational path to an
    // output.
    assign in_ready  = (stateQ == ACC);
    assign out_valid = (stateQ == OUT);
    assign grad      = gradQ;
    assign elem_idx  = idxQ;

endmodule

// File: tb/tb_sgd_grad_gen.sv
// ---------------------------------------------------------------------------
// tb_sgd_grad_gen
//
// Directed self-checking bench for sgd_grad_gen. It uses two instances:
// one with num_elem=4 for the multi-beat scenarios, and one with
// num_elem=1 for the single-beat wrap-around scenario. Inputs change 1 time
// unit after a rising edge, and outputs are sampled at that same point, so
// nothing is sampled on the active edge.
// ---------------------------------------------------------------------------
module tb_sgd_grad_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Instance with four elements per vector
    logic        inValid4 = 1'b0;
    logic        inReady4;
    logic [7:0]  x4 = '0;
    logic [15:0] w4 = '0;
    logic [15:0] y4 = '0;
    logic [7:0]  mu4 = '0;
    logic        outValid4;
    logic        outReady4 = 1'b1;
    logic [15:0] grad4;
    logic [1:0]  elemIdx4;

    // Instance with one element per vector
    logic        inValid1 = 1'b0;
    logic        inReady1;
    logic [7:0]  x1 = '0;
    logic [15:0] w1 = '0;
    logic [15:0] y1 = '0;
    logic [7:0]  mu1 = '0;
    logic        outValid1;
    logic        outReady1 = 1'b1;
    logic [15:0] grad1;
    logic [0:0]  elemIdx1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int markA = 0;
    int markB = 0;
    int markC = 0;

    sgd_grad_gen #(.bitwidth(16), .inputBitwidth(8), .num_elem(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid4),
        .in_ready  (inReady4),
        .x         (x4),
        .w         (w4),
        .y         (y4),
        .mu        (mu4),
        .out_valid (outValid4),
        .out_ready (outReady4),
        .grad      (grad4),
        .elem_idx  (elemIdx4)
    );

    sgd_grad_gen #(.bitwidth(16), .inputBitwidth(8), .num_elem(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid1),
        .in_ready  (inReady1),
        .x         (x1),
        .w         (w1),
        .y         (y1),
        .mu        (mu1),
        .out_valid (outValid1),
        .out_ready (outReady1),
        .grad      (grad1),
        .elem_idx  (elemIdx1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one beat to the 4-element instance for one edge. in_valid is
    // left high afterwards, and the caller drops it when a gap is wanted.
    task automatic applyStimulus(input logic [7:0] xv, input logic [15:0] wv,
                                 input logic [15:0] yv, input logic [7:0] muv);
        inValid4 = 1'b1;
        x4 = xv;
        w4 = wv;
        y4 = yv;
        mu4 = muv;
        tick();
    endtask

    task automatic applyStimulus1(input logic [7:0] xv, input logic [15:0] wv,
                                  input logic [15:0] yv, input logic [7:0] muv);
        inValid1 = 1'b1;
        x1 = xv;
        w1 = wv;
        y1 = yv;
        mu1 = muv;
        tick();
        inValid1 = 1'b0;
    endtask

    initial begin
        // ---------------- Reset state ----------------
        rst = 1'b1;
        tick();
        tick();
        checkOutput("rst_in_ready", 32'(inReady4), 32'd1);
        checkOutput("rst_out_valid", 32'(outValid4), 32'd0);
        checkOutput("rst_grad", 32'(grad4), 32'd0);
        checkOutput("rst_elem_idx", 32'(elemIdx4), 32'd0);
        checkOutput("rst_in_ready_n1", 32'(inReady1), 32'd1);
        rst = 1'b0;
        tick();

        // ---------------- Basic vector: acc=300, err=200, grad=400 ----------------
        outReady4 = 1'b1;
        applyStimulus(8'd1, 16'd10, 16'd100, 8'd2);
        checkOutput("basic_idx1", 32'(elemIdx4), 32'd1);
        applyStimulus(8'd2, 16'd20, 16'd100, 8'd2);
        applyStimulus(8'd3, 16'd30, 16'd100, 8'd2);
        applyStimulus(8'd4, 16'd40, 16'd100, 8'd2);
        inValid4 = 1'b0;
        checkOutput("basic_calc_in_ready", 32'(inReady4), 32'd0);
        checkOutput("basic_calc_out_valid", 32'(outValid4), 32'd0);
        checkOutput("basic_calc_idx", 32'(elemIdx4), 32'd0);
        tick();
        checkOutput("basic_out_valid", 32'(outValid4), 32'd1);
        checkOutput("basic_grad", 32'(grad4), 32'd400);
        tick();
        checkOutput("basic_out_valid_drop", 32'(outValid4), 32'd0);
        checkOutput("basic_in_ready_back", 32'(inReady4), 32'd1);

        // ---------------- Input bubbles 1,0,0,1,0,1,1 ----------------
        applyStimulus(8'd1, 16'd10, 16'd0, 8'd0);
        inValid4 = 1'b0; x4 = 8'd99; w4 = 16'd99;
        tick();
        checkOutput("bubble_idx_hold1", 32'(elemIdx4), 32'd1);
        tick();
        checkOutput("bubble_idx_hold2", 32'(elemIdx4), 32'd1);
        applyStimulus(8'd2, 16'd20, 16'd0, 8'd0);
        checkOutput("bubble_idx2", 32'(elemIdx4), 32'd2);
        inValid4 = 1'b0; x4 = 8'd77; w4 = 16'd77;
        tick();
        checkOutput("bubble_idx_hold3", 32'(elemIdx4), 32'd2);
        applyStimulus(8'd3, 16'd30, 16'd0, 8'd0);
        applyStimulus(8'd4, 16'd40, 16'd100, 8'd2);
        inValid4 = 1'b0;
        tick();
        checkOutput("bubble_out_valid", 32'(outValid4), 32'd1);
        checkOutput("bubble_grad", 32'(grad4), 32'd400);
        tick();

        // ---------------- Backpressure: acc=20, err=16, grad=48 ----------------
        outReady4 = 1'b0;
        applyStimulus(8'd1, 16'd5, 16'd4, 8'd3);
        applyStimulus(8'd1, 16'd5, 16'd4, 8'd3);
        applyStimulus(8'd1, 16'd5, 16'd4, 8'd3);
        applyStimulus(8'd1, 16'd5, 16'd4, 8'd3);
        x4 = 8'd7; w4 = 16'd7;
        tick();
        checkOutput("bp_out_valid_rise", 32'(outValid4), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("bp_out_valid_%0d", i), 32'(outValid4), 32'd1);
            checkOutput($sformatf("bp_grad_%0d", i), 32'(grad4), 32'd48);
            checkOutput($sformatf("bp_in_ready_%0d", i), 32'(inReady4), 32'd0);
            checkOutput($sformatf("bp_idx_%0d", i), 32'(elemIdx4), 32'd0);
        end
        outReady4 = 1'b1;
        tick();
        checkOutput("bp_release_out_valid", 32'(outValid4), 32'd0);
        checkOutput("bp_release_in_ready", 32'(inReady4), 32'd1);
        checkOutput("bp_release_idx", 32'(elemIdx4), 32'd0);
        // Next vector starts from acc=0: 4*(2*3)=24, y=0, mu=1 -> 24
        applyStimulus(8'd2, 16'd3, 16'd0, 8'd1);
        checkOutput("bp_next_first_beat", 32'(elemIdx4), 32'd1);
        applyStimulus(8'd2, 16'd3, 16'd0, 8'd1);
        applyStimulus(8'd2, 16'd3, 16'd0, 8'd1);
        applyStimulus(8'd2, 16'd3, 16'd0, 8'd1);
        inValid4 = 1'b0;
        tick();
        checkOutput("bp_next_grad", 32'(grad4), 32'd24);
        tick();

        // ---------------- Wrap-around with num_elem=1 ----------------
        applyStimulus1(8'd2, 16'hFFFF, 16'd0, 8'd1);
        checkOutput("wrap1_in_ready", 32'(inReady1), 32'd0);
        checkOutput("wrap1_idx", 32'(elemIdx1), 32'd0);
        tick();
        checkOutput("wrap1_out_valid", 32'(outValid1), 32'd1);
        checkOutput("wrap1_grad", 32'(grad1), 32'hFFFE);
        tick();
        applyStimulus1(8'd1, 16'd5, 16'd6, 8'd3);
        tick();
        checkOutput("wrap2_grad", 32'(grad1), 32'hFFFD);
        tick();

        // ---------------- Reset mid-vector ----------------
        applyStimulus(8'd9, 16'd9, 16'd0, 8'd0);
        applyStimulus(8'd9, 16'd9, 16'd0, 8'd0);
        checkOutput("midrst_pre_idx", 32'(elemIdx4), 32'd2);
        inValid4 = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midrst_in_ready", 32'(inReady4), 32'd1);
        checkOutput("midrst_out_valid", 32'(outValid4), 32'd0);
        checkOutput("midrst_grad", 32'(grad4), 32'd0);
        checkOutput("midrst_idx", 32'(elemIdx4), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        // acc=4, err=3, mu=5 -> 15
        applyStimulus(8'd1, 16'd1, 16'd0, 8'd0);
        applyStimulus(8'd1, 16'd1, 16'd0, 8'd0);
        applyStimulus(8'd1, 16'd1, 16'd0, 8'd0);
        applyStimulus(8'd1, 16'd1, 16'd1, 8'd5);
        inValid4 = 1'b0;
        tick();
        checkOutput("midrst_next_grad", 32'(grad4), 32'd15);
        tick();

        // ---------------- Back-to-back vectors, junk y/mu on non-final beats ----------------
        // A: x=1..4, w=1 -> acc=10, y=3, mu=2 -> 14
        applyStimulus(8'd1, 16'd1, 16'hDEAD, 8'hAA);
        applyStimulus(8'd2, 16'd1, 16'hBEEF, 8'h55);
        applyStimulus(8'd3, 16'd1, 16'h1234, 8'h33);
        applyStimulus(8'd4, 16'd1, 16'd3, 8'd2);
        x4 = 8'd2; w4 = 16'd2; y4 = 16'hAAAA; mu4 = 8'hFF;
        tick();
        checkOutput("b2b_a_grad", 32'(grad4), 32'd14);
        checkOutput("b2b_a_valid", 32'(outValid4), 32'd1);
        markA = cyc;
        tick();
        // B: x=2, w=2 -> acc=16, y=20, mu=1 -> 0xFFFC
        applyStimulus(8'd2, 16'd2, 16'hAAAA, 8'hFF);
        applyStimulus(8'd2, 16'd2, 16'h0F0F, 8'h11);
        applyStimulus(8'd2, 16'd2, 16'h7777, 8'h22);
        applyStimulus(8'd2, 16'd2, 16'd20, 8'd1);
        x4 = 8'd255; w4 = 16'h0101; y4 = 16'h5555; mu4 = 8'h44;
        tick();
        checkOutput("b2b_b_grad", 32'(grad4), 32'hFFFC);
        checkOutput("b2b_b_valid", 32'(outValid4), 32'd1);
        markB = cyc;
        tick();
        // C: 4 * (255*257 = 0xFFFF) -> acc=0xFFFC, y=0xFFF0, mu=7 -> 84
        applyStimulus(8'd255, 16'h0101, 16'h5555, 8'h44);
        applyStimulus(8'd255, 16'h0101, 16'h6666, 8'h66);
        applyStimulus(8'd255, 16'h0101, 16'h9999, 8'h99);
        applyStimulus(8'd255, 16'h0101, 16'hFFF0, 8'd7);
        inValid4 = 1'b0;
        tick();
        checkOutput("b2b_c_grad", 32'(grad4), 32'd84);
        checkOutput("b2b_c_valid", 32'(outValid4), 32'd1);
        markC = cyc;
        checkOutput("b2b_spacing_ab", 32'(markB - markA), 32'd6);
        checkOutput("b2b_spacing_bc", 32'(markC - markB), 32'd6);
        tick();
        checkOutput("b2b_end_in_ready", 32'(inReady4), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
